// File: rtl/vga_fb_reader_if.sv
// rtl/vga_fb_reader_if.sv - frame buffer port-B bus between the VGA reader and the BRAM
interface vga_fb_reader_if #(
    parameter int AW = 19
);
    logic          enb_o;
    logic          web_o;
    logic [AW-1:0] addrb_o;
    logic [7:0]    mem2db_i;

    modport master (
        output enb_o,
        output web_o,
        output addrb_o,
        input  mem2db_i
    );

    modport slave (
        input  enb_o,
        input  web_o,
        input  addrb_o,
        output mem2db_i
    );
endinterface

// File: rtl/vga_fb_reader.sv
// rtl/vga_fb_reader.sv - VGA timing generator and RGB332 frame buffer port-B reader
module vga_fb_reader #(
    parameter int H_ACT    = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACT    = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int PIX_DIV  = 4,
    parameter int RD_LAT   = 2,
    parameter bit SYNC_POL = 1'b0,
    parameter int AW       = 19
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   disp_en_i,
    vga_fb_reader_if.master        fb,
    output logic                   vga_hs_o,
    output logic                   vga_vs_o,
    output logic [3:0]             vga_r_o,
    output logic [3:0]             vga_g_o,
    output logic [3:0]             vga_b_o,
    output logic                   frame_start_o
);

    localparam int H_TOT   = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int V_TOT   = V_ACT + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOT);
    localparam int VW      = $clog2(V_TOT);
    localparam int DW      = $clog2(PIX_DIV);
    localparam int PIX_MAX = H_ACT * V_ACT - 1;
    localparam int HS_BEG  = H_ACT + H_FP;
    localparam int HS_END  = H_ACT + H_FP + H_SYNC - 1;
    localparam int VS_BEG  = V_ACT + V_FP;
    localparam int VS_END  = V_ACT + V_FP + V_SYNC - 1;

    logic [DW-1:0]     div_cnt;
    logic [HW-1:0]     h_cnt;
    logic [VW-1:0]     v_cnt;
    logic              disp_latch;
    logic [AW-1:0]     rd_cnt;
    logic [RD_LAT-1:0] rd_pipe;
    logic [7:0]        pix_hold;
    logic [HW-1:0]     h_dly;
    logic [VW-1:0]     v_dly;
    logic              show_dly;

    logic pix_tick;
    logic h_last;
    logic v_last;
    logic frame_start;
    logic in_active;
    logic latch_eff;
    logic rd_en;

    // Tick, position and read-request decode from the registered counters.
    // At frame start the new latch value is used directly so pixel (0,0)
    // already follows the freshly sampled disp_en_i.
    always_comb begin
        pix_tick    = (div_cnt == DW'(PIX_DIV - 1));
        h_last      = (h_cnt == HW'(H_TOT - 1));
        v_last      = (v_cnt == VW'(V_TOT - 1));
        frame_start = pix_tick && (h_cnt == '0) && (v_cnt == '0);
        in_active   = (h_cnt < HW'(H_ACT)) && (v_cnt < VW'(V_ACT));
        latch_eff   = frame_start ? disp_en_i : disp_latch;
        rd_en       = pix_tick && in_active && latch_eff;
    end

    assign fb.enb_o       = rd_en;
    assign fb.web_o       = 1'b0;
    assign fb.addrb_o     = rd_cnt;
    assign frame_start_o  = frame_start;

    // Pixel clock divider: one pix_tick every PIX_DIV clocks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (pix_tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Raster position counters, advanced once per pixel tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_tick) begin
            if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    // Display enable is frozen for a whole frame at its first tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_latch <= 1'b0;
        end else if (frame_start) begin
            disp_latch <= disp_en_i;
        end
    end

    // Linear read address; cleared on the last tick of the frame so the
    // next frame-start read is address 0, saturating at the last pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt <= '0;
        end else if (pix_tick) begin
            if (h_last && v_last) begin
                rd_cnt <= '0;
            end else if (rd_en && (rd_cnt != AW'(PIX_MAX))) begin
                rd_cnt <= rd_cnt + 1'b1;
            end
        end
    end

    // Track outstanding reads and capture BRAM data RD_LAT clocks after enb.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pipe  <= '0;
            pix_hold <= '0;
        end else begin
            rd_pipe[0] <= rd_en;
            for (int i = 1; i < RD_LAT; i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end
            if (rd_pipe[RD_LAT-1]) begin
                pix_hold <= fb.mem2db_i;
            end
        end
    end

    // Delay position and visibility by one tick to meet the returning data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_dly    <= '0;
            v_dly    <= '0;
            show_dly <= 1'b0;
        end else if (pix_tick) begin
            h_dly    <= h_cnt;
            v_dly    <= v_cnt;
            show_dly <= in_active && latch_eff;
        end
    end

    // Pin stage: sync decode and RGB332 to 4:4:4 expansion, once per tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vga_hs_o <= ~SYNC_POL;
            vga_vs_o <= ~SYNC_POL;
            vga_r_o  <= '0;
            vga_g_o  <= '0;
            vga_b_o  <= '0;
        end else if (pix_tick) begin
            vga_hs_o <= ((h_dly >= HW'(HS_BEG)) && (h_dly <= HW'(HS_END))) ? SYNC_POL : ~SYNC_POL;
            vga_vs_o <= ((v_dly >= VW'(VS_BEG)) && (v_dly <= VW'(VS_END))) ? SYNC_POL : ~SYNC_POL;
            if (show_dly) begin
                vga_r_o <= {pix_hold[7:5], pix_hold[7]};
                vga_g_o <= {pix_hold[4:2], pix_hold[4]};
                vga_b_o <= {pix_hold[1:0], pix_hold[1:0]};
            end else begin
                vga_r_o <= '0;
                vga_g_o <= '0;
                vga_b_o <= '0;
            end
        end
    end

endmodule

// File: tb/tb_vga_fb_reader.sv
// tb/tb_vga_fb_reader.sv - scoreboard bench for vga_fb_reader on a reduced raster
module tb_vga_fb_reader;

    localparam int H_ACT    = 8;
    localparam int H_FP     = 2;
    localparam int H_SYNC   = 3;
    localparam int H_BP     = 2;
    localparam int V_ACT    = 6;
    localparam int V_FP     = 1;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 1;
    localparam int PIX_DIV  = 4;
    localparam int RD_LAT   = 2;
    localparam bit SYNC_POL = 1'b0;
    localparam int AW       = 19;
    localparam int H_TOT    = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int V_TOT    = V_ACT + V_FP + V_SYNC + V_BP;
    localparam int PIX      = H_ACT * V_ACT;
    localparam int FRAME    = H_TOT * V_TOT * PIX_DIV;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } pins_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       disp_en_i = 1'b0;
    logic       vga_hs_o, vga_vs_o, frame_start_o;
    logic [3:0] vga_r_o, vga_g_o, vga_b_o;

    vga_fb_reader_if #(.AW(AW)) fb();

    vga_fb_reader #(
        .H_ACT(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACT(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .PIX_DIV(PIX_DIV), .RD_LAT(RD_LAT), .SYNC_POL(SYNC_POL), .AW(AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .disp_en_i(disp_en_i),
        .fb(fb),
        .vga_hs_o(vga_hs_o),
        .vga_vs_o(vga_vs_o),
        .vga_r_o(vga_r_o),
        .vga_g_o(vga_g_o),
        .vga_b_o(vga_b_o),
        .frame_start_o(frame_start_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] exp3(input logic [2:0] c);
        return 4'(int'(c) * 2 + int'(c) / 4);
    endfunction

    function automatic logic [3:0] exp2(input logic [1:0] c);
        return 4'(int'(c) * 5);
    endfunction

    // Frame buffer contents and a BRAM with RD_LAT output stages; garbage
    // flows through when not enabled so a mistimed capture shows up.
    logic [7:0] mem [PIX];
    logic [7:0] bram_pipe [RD_LAT];

    always @(posedge clk) begin
        if (fb.enb_o && (int'(fb.addrb_o) < PIX))
            bram_pipe[0] <= mem[fb.addrb_o];
        else
            bram_pipe[0] <= 8'($urandom);
        for (int i = 1; i < RD_LAT; i++)
            bram_pipe[i] <= bram_pipe[i-1];
    end
    assign fb.mem2db_i = bram_pipe[RD_LAT-1];

    // Reference model: tick k after release sits at raster position
    // (k mod H_TOT, (k div H_TOT) mod V_TOT); pins show tick k two ticks later.
    int    clk_since = 0;
    bit    frame_on  = 1'b0;
    int    rd_q[$];
    int    fs_q[$];
    pins_t pin_q[$];
    pins_t idle_pins;

    always @(posedge clk) begin : model
        int         k, h, v, a;
        pins_t      rec;
        logic [7:0] d;
        idle_pins = '{hs: !SYNC_POL, vs: !SYNC_POL, r: 4'h0, g: 4'h0, b: 4'h0};
        if (rst) begin
            clk_since = 0;
            rd_q.delete();
            fs_q.delete();
            pin_q.delete();
            pin_q.push_back(idle_pins);
            pin_q.push_back(idle_pins);
        end else begin
            clk_since++;
            if (clk_since % PIX_DIV == PIX_DIV - 1) begin
                k = clk_since / PIX_DIV;
                h = k % H_TOT;
                v = (k / H_TOT) % V_TOT;
                if (h == 0 && v == 0) begin
                    frame_on = disp_en_i;
                    fs_q.push_back(clk_since);
                end
                rec.hs = (h >= H_ACT + H_FP && h < H_ACT + H_FP + H_SYNC) ? SYNC_POL : !SYNC_POL;
                rec.vs = (v >= V_ACT + V_FP && v < V_ACT + V_FP + V_SYNC) ? SYNC_POL : !SYNC_POL;
                if (h < H_ACT && v < V_ACT && frame_on) begin
                    a = v * H_ACT + h;
                    rd_q.push_back(a);
                    d = mem[a];
                    rec.r = exp3(d[7:5]);
                    rec.g = exp3(d[4:2]);
                    rec.b = exp2(d[1:0]);
                end else begin
                    rec.r = 4'h0;
                    rec.g = 4'h0;
                    rec.b = 4'h0;
                end
                pin_q.push_back(rec);
            end
        end
    end

    // Monitor: compares reads, frame-start pulses and pins as they appear.
    always @(negedge clk) begin : monitor
        int    ea;
        pins_t ep;
        if (!rst) begin
            if (fb.enb_o) begin
                if (rd_q.size() == 0) begin
                    chk("unexpected_enb", 32'(fb.addrb_o), 32'hFFFF_FFFF);
                end else begin
                    ea = rd_q.pop_front();
                    chk("addrb", 32'(fb.addrb_o), 32'(ea));
                end
            end
            if (frame_start_o) begin
                if (fs_q.size() == 0) begin
                    chk("unexpected_frame_start", 32'(clk_since), 32'hFFFF_FFFF);
                end else begin
                    ea = fs_q.pop_front();
                    chk("frame_start_clk", 32'(clk_since), 32'(ea));
                end
            end
            if (clk_since % PIX_DIV == PIX_DIV - 1) begin
                if (pin_q.size() == 0) begin
                    chk("pin_queue_empty", 32'(clk_since), 32'hFFFF_FFFF);
                end else begin
                    ep = pin_q.pop_front();
                    chk("hs", 32'(vga_hs_o), 32'(ep.hs));
                    chk("vs", 32'(vga_vs_o), 32'(ep.vs));
                    chk("r",  32'(vga_r_o),  32'(ep.r));
                    chk("g",  32'(vga_g_o),  32'(ep.g));
                    chk("b",  32'(vga_b_o),  32'(ep.b));
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_hs"},  32'(vga_hs_o),      32'(!SYNC_POL));
        chk({tag, "_vs"},  32'(vga_vs_o),      32'(!SYNC_POL));
        chk({tag, "_r"},   32'(vga_r_o),       32'h0);
        chk({tag, "_g"},   32'(vga_g_o),       32'h0);
        chk({tag, "_b"},   32'(vga_b_o),       32'h0);
        chk({tag, "_enb"}, 32'(fb.enb_o),      32'h0);
        chk({tag, "_web"}, 32'(fb.web_o),      32'h0);
        chk({tag, "_addr"}, 32'(fb.addrb_o),   32'h0);
        chk({tag, "_fs"},  32'(frame_start_o), 32'h0);
    endtask

    initial begin
        int guard;
        for (int i = 0; i < PIX; i++) mem[i] = 8'($urandom);
        mem[0]       = 8'h00;
        mem[1]       = 8'h01;
        mem[PIX - 1] = 8'hFF;

        rst = 1'b1;
        disp_en_i = 1'b1;
        repeat (10) @(negedge clk);
        check_reset_outputs("rst_hold");
        rst = 1'b0;

        // Frame 0 displayed; drop enable in line 3 of frame 1 (still shown),
        // frame 2 then black; re-enable so frame 3 is shown.
        repeat (FRAME + 3 * H_TOT * PIX_DIV) @(negedge clk);
        disp_en_i = 1'b0;
        repeat (FRAME) @(negedge clk);
        disp_en_i = 1'b1;
        repeat (FRAME) @(negedge clk);

        // Random enable toggling, including mid-frame changes.
        for (int n = 0; n < 4 * FRAME; n++) begin
            @(negedge clk);
            if ($urandom_range(0, 149) == 0) disp_en_i = ~disp_en_i;
        end
        disp_en_i = 1'b1;
        repeat (FRAME) @(negedge clk);

        // Reset one clock after the read of pixel (5,2), with data in flight.
        guard = 0;
        while ((clk_since % FRAME) != (3 + PIX_DIV * (2 * H_TOT + 5) + 1) && guard < 2 * FRAME) begin
            @(negedge clk);
            guard++;
        end
        chk("locate_timeout", 32'(guard < 2 * FRAME), 32'h1);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        repeat (3) @(negedge clk);
        check_reset_outputs("rst_mid_hold");
        rst = 1'b0;
        disp_en_i = ($urandom_range(0, 1) == 1);
        repeat (2 * FRAME + 50) @(negedge clk);
        #1;
        chk("reads_outstanding", 32'(rd_q.size()), 32'h0);
        chk("frame_starts_outstanding", 32'(fs_q.size()), 32'h0);
        chk("pins_outstanding", 32'(pin_q.size()), 32'h2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
